// File: rtl/piton_aws_axi_range_guard_if.sv
// AXI4 bundle between the DDR address translator, the range guard and the shell DDR port.
// 'master' is the view of a block that receives the translator's master-side signals.
interface axi_bus_t #(
  parameter int unsigned C_M_AXI4_ID_WIDTH   = 16,
  parameter int unsigned C_M_AXI4_ADDR_WIDTH = 64,
  parameter int unsigned C_M_AXI4_DATA_WIDTH = 512,
  parameter int unsigned C_M_AXI4_USER_WIDTH = 1
);
  logic [C_M_AXI4_ID_WIDTH-1:0]     awid;
  logic [C_M_AXI4_ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]                       awlen;
  logic [2:0]                       awsize;
  logic [1:0]                       awburst;
  logic                             awlock;
  logic [3:0]                       awcache;
  logic [2:0]                       awprot;
  logic [3:0]                       awqos;
  logic [3:0]                       awregion;
  logic [C_M_AXI4_USER_WIDTH-1:0]   awuser;
  logic                             awvalid;
  logic                             awready;

  logic [C_M_AXI4_DATA_WIDTH-1:0]   wdata;
  logic [C_M_AXI4_DATA_WIDTH/8-1:0] wstrb;
  logic                             wlast;
  logic [C_M_AXI4_USER_WIDTH-1:0]   wuser;
  logic                             wvalid;
  logic                             wready;

  logic [C_M_AXI4_ID_WIDTH-1:0]     bid;
  logic [1:0]                       bresp;
  logic [C_M_AXI4_USER_WIDTH-1:0]   buser;
  logic                             bvalid;
  logic                             bready;

  logic [C_M_AXI4_ID_WIDTH-1:0]     arid;
  logic [C_M_AXI4_ADDR_WIDTH-1:0]   araddr;
  logic [7:0]                       arlen;
  logic [2:0]                       arsize;
  logic [1:0]                       arburst;
  logic                             arlock;
  logic [3:0]                       arcache;
  logic [2:0]                       arprot;
  logic [3:0]                       arqos;
  logic [3:0]                       arregion;
  logic [C_M_AXI4_USER_WIDTH-1:0]   aruser;
  logic                             arvalid;
  logic                             arready;

  logic [C_M_AXI4_ID_WIDTH-1:0]     rid;
  logic [C_M_AXI4_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                       rresp;
  logic                             rlast;
  logic [C_M_AXI4_USER_WIDTH-1:0]   ruser;
  logic                             rvalid;
  logic                             rready;

  modport master (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
    input  awuser, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
    input  aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );

  modport slave (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
    output awuser, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bid, bresp, buser, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
    output aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );
endinterface

// File: rtl/piton_aws_axi_range_guard.sv
// Forwards in-window AXI4 traffic to DDR and terminates out-of-window bursts with DECERR.
// Optional error log ports/logic: define PITON_AWS_RANGE_GUARD_ERR_LOG_EN.
module piton_aws_axi_range_guard #(
  parameter logic [63:0] ADDR_LIMIT          = 64'h10_0000_0000,
  parameter int unsigned MAX_OUTSTANDING     = 16,
  parameter int unsigned C_M_AXI4_ID_WIDTH   = 16,
  parameter int unsigned C_M_AXI4_ADDR_WIDTH = 64,
  parameter int unsigned C_M_AXI4_DATA_WIDTH = 512,
  parameter int unsigned C_M_AXI4_USER_WIDTH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  axi_bus_t.master   in,
  axi_bus_t.slave    out
`ifdef PITON_AWS_RANGE_GUARD_ERR_LOG_EN
  ,
  output logic [15:0]                    rd_err_cnt,
  output logic [15:0]                    wr_err_cnt,
  output logic [C_M_AXI4_ADDR_WIDTH-1:0] first_err_addr,
  output logic                           first_err_vld
`endif
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_OUTSTANDING);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [1:0] {WIdle, WPass, WSink, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RDrain, RErr} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic [CntW-1:0] wr_cnt_q, rd_cnt_q;
  logic [C_M_AXI4_ID_WIDTH-1:0] bid_q, bid_d, rid_q, rid_d;
  logic [7:0] rlen_q, rlen_d, beat_q, beat_d;

  logic aw_in_range, ar_in_range;
  logic wr_room, rd_room;
  logic wr_inc, wr_dec, rd_inc, rd_dec;
  logic rd_drained;

  // Last byte of the burst, in 65 bits so bursts near 2^64 cannot wrap back into the window.
  function automatic logic in_window(input logic [C_M_AXI4_ADDR_WIDTH-1:0] addr,
                                     input logic [7:0] len, input logic [2:0] size);
    logic [64:0] last;
    last = 65'(addr) + ((65'(len) + 65'd1) << size) - 65'd1;
    return last < {1'b0, ADDR_LIMIT};
  endfunction

  assign aw_in_range = in_window(in.awaddr, in.awlen, in.awsize);
  assign ar_in_range = in_window(in.araddr, in.arlen, in.arsize);
  assign wr_room     = wr_cnt_q < CntMax;
  assign rd_room     = rd_cnt_q < CntMax;

  // Address and data fields always follow their source; only valid/ready are gated.
  assign out.awid     = in.awid;
  assign out.awaddr   = in.awaddr;
  assign out.awlen    = in.awlen;
  assign out.awsize   = in.awsize;
  assign out.awburst  = in.awburst;
  assign out.awlock   = in.awlock;
  assign out.awcache  = in.awcache;
  assign out.awprot   = in.awprot;
  assign out.awqos    = in.awqos;
  assign out.awregion = in.awregion;
  assign out.awuser   = in.awuser;
  assign out.wdata    = in.wdata;
  assign out.wstrb    = in.wstrb;
  assign out.wlast    = in.wlast;
  assign out.wuser    = in.wuser;
  assign out.arid     = in.arid;
  assign out.araddr   = in.araddr;
  assign out.arlen    = in.arlen;
  assign out.arsize   = in.arsize;
  assign out.arburst  = in.arburst;
  assign out.arlock   = in.arlock;
  assign out.arcache  = in.arcache;
  assign out.arprot   = in.arprot;
  assign out.arqos    = in.arqos;
  assign out.arregion = in.arregion;
  assign out.aruser   = in.aruser;

  // ---------------- Write path ----------------
  always_comb begin
    w_state_d   = w_state_q;
    bid_d       = bid_q;
    out.awvalid = 1'b0;
    in.awready  = 1'b0;
    out.wvalid  = 1'b0;
    in.wready   = 1'b0;
    in.bvalid   = out.bvalid;
    in.bid      = out.bid;
    in.bresp    = out.bresp;
    in.buser    = out.buser;
    out.bready  = in.bready;
    unique case (w_state_q)
      WIdle: begin
        if (aw_in_range) begin
          out.awvalid = in.awvalid && wr_room;
          in.awready  = out.awready && wr_room;
          if (out.awvalid && out.awready) w_state_d = WPass;
        end else begin
          in.awready = 1'b1;
          if (in.awvalid) begin
            bid_d     = in.awid;
            w_state_d = WSink;
          end
        end
      end
      WPass: begin
        out.wvalid = in.wvalid;
        in.wready  = out.wready;
        if (in.wvalid && out.wready && in.wlast) w_state_d = WIdle;
      end
      WSink: begin
        in.wready = 1'b1;
        if (in.wvalid && in.wlast) w_state_d = WResp;
      end
      WResp: begin
        // Hold the error B until every earlier forwarded write has been answered.
        if (wr_cnt_q == '0) begin
          in.bvalid  = 1'b1;
          in.bid     = bid_q;
          in.bresp   = 2'b11;
          in.buser   = {C_M_AXI4_USER_WIDTH{1'b0}};
          out.bready = 1'b0;
          if (in.bready) w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  assign wr_inc = out.awvalid && out.awready;
  assign wr_dec = out.bvalid && out.bready && (wr_cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= WIdle;
      bid_q     <= '0;
      wr_cnt_q  <= '0;
    end else begin
      w_state_q <= w_state_d;
      bid_q     <= bid_d;
      if (wr_inc && !wr_dec) begin
        wr_cnt_q <= wr_cnt_q + CntOne;
      end else if (wr_dec && !wr_inc) begin
        wr_cnt_q <= wr_cnt_q - CntOne;
      end
    end
  end

  // ---------------- Read path ----------------
  // R passes through outside RErr, so a final rlast handshake this cycle empties the counter.
  assign rd_drained = (rd_cnt_q == '0) ||
                      ((rd_cnt_q == CntOne) && out.rvalid && in.rready && out.rlast);

  always_comb begin
    r_state_d   = r_state_q;
    rid_d       = rid_q;
    rlen_d      = rlen_q;
    beat_d      = beat_q;
    out.arvalid = 1'b0;
    in.arready  = 1'b0;
    in.rvalid   = out.rvalid;
    in.rid      = out.rid;
    in.rdata    = out.rdata;
    in.rresp    = out.rresp;
    in.rlast    = out.rlast;
    in.ruser    = out.ruser;
    out.rready  = in.rready;
    unique case (r_state_q)
      RIdle: begin
        if (ar_in_range) begin
          out.arvalid = in.arvalid && rd_room;
          in.arready  = out.arready && rd_room;
        end else begin
          in.arready = 1'b1;
          if (in.arvalid) begin
            rid_d     = in.arid;
            rlen_d    = in.arlen;
            beat_d    = '0;
            r_state_d = rd_drained ? RErr : RDrain;
          end
        end
      end
      RDrain: begin
        if (rd_drained) r_state_d = RErr;
      end
      RErr: begin
        in.rvalid  = 1'b1;
        in.rid     = rid_q;
        in.rdata   = {C_M_AXI4_DATA_WIDTH{1'b0}};
        in.rresp   = 2'b11;
        in.rlast   = (beat_q == rlen_q);
        in.ruser   = {C_M_AXI4_USER_WIDTH{1'b0}};
        out.rready = 1'b0;
        if (in.rready) begin
          beat_d = beat_q + 8'd1;
          if (beat_q == rlen_q) r_state_d = RIdle;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  assign rd_inc = out.arvalid && out.arready;
  assign rd_dec = out.rvalid && out.rready && out.rlast && (rd_cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= RIdle;
      rid_q     <= '0;
      rlen_q    <= '0;
      beat_q    <= '0;
      rd_cnt_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      rlen_q    <= rlen_d;
      beat_q    <= beat_d;
      if (rd_inc && !rd_dec) begin
        rd_cnt_q <= rd_cnt_q + CntOne;
      end else if (rd_dec && !rd_inc) begin
        rd_cnt_q <= rd_cnt_q - CntOne;
      end
    end
  end

`ifdef PITON_AWS_RANGE_GUARD_ERR_LOG_EN
  logic aw_local_acc, ar_local_acc;

  assign aw_local_acc = (w_state_q == WIdle) && !aw_in_range && in.awvalid;
  assign ar_local_acc = (r_state_q == RIdle) && !ar_in_range && in.arvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_err_cnt     <= '0;
      wr_err_cnt     <= '0;
      first_err_addr <= '0;
      first_err_vld  <= 1'b0;
    end else begin
      if (ar_local_acc && (rd_err_cnt != 16'hFFFF)) rd_err_cnt <= rd_err_cnt + 16'd1;
      if (aw_local_acc && (wr_err_cnt != 16'hFFFF)) wr_err_cnt <= wr_err_cnt + 16'd1;
      // Write side wins when both channels reject in the same cycle.
      if (!first_err_vld && (aw_local_acc || ar_local_acc)) begin
        first_err_addr <= aw_local_acc ? in.awaddr : in.araddr;
        first_err_vld  <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_piton_aws_axi_range_guard.sv
// Self-checking bench for piton_aws_axi_range_guard: directed scenarios plus random bursts.
module tb_piton_aws_axi_range_guard;

  localparam logic [63:0] Limit = 64'h10_0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  axi_bus_t #(.C_M_AXI4_DATA_WIDTH(64)) in_bus ();
  axi_bus_t #(.C_M_AXI4_DATA_WIDTH(64)) out_bus ();

  piton_aws_axi_range_guard #(
    .C_M_AXI4_DATA_WIDTH(64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in_bus),
    .out   (out_bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference rule: the burst covers [addr, addr + bytes) and must end at or below the limit.
  function automatic bit model_ok(input logic [63:0] addr, input logic [7:0] len,
                                  input logic [2:0] size);
    logic [127:0] end_excl;
    end_excl = 128'(addr) + (128'(len) + 128'd1) * (128'd1 << size);
    return end_excl <= 128'(Limit);
  endfunction

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    case ($urandom_range(0, 3))
      0:       a = {28'd0, 4'($urandom), $urandom};
      1:       a = Limit - 64'($urandom_range(0, 2048));
      2:       a = Limit + 64'($urandom_range(0, 4096));
      default: a = {$urandom, $urandom};
    endcase
    return a;
  endfunction

  task automatic clear_inputs();
    in_bus.awid = '0; in_bus.awaddr = '0; in_bus.awlen = '0; in_bus.awsize = '0;
    in_bus.awburst = 2'b01; in_bus.awlock = 1'b0; in_bus.awcache = '0; in_bus.awprot = '0;
    in_bus.awqos = '0; in_bus.awregion = '0; in_bus.awuser = '0; in_bus.awvalid = 1'b0;
    in_bus.wdata = '0; in_bus.wstrb = '1; in_bus.wlast = 1'b0; in_bus.wuser = '0;
    in_bus.wvalid = 1'b0; in_bus.bready = 1'b0;
    in_bus.arid = '0; in_bus.araddr = '0; in_bus.arlen = '0; in_bus.arsize = '0;
    in_bus.arburst = 2'b01; in_bus.arlock = 1'b0; in_bus.arcache = '0; in_bus.arprot = '0;
    in_bus.arqos = '0; in_bus.arregion = '0; in_bus.aruser = '0; in_bus.arvalid = 1'b0;
    in_bus.rready = 1'b0;
    out_bus.awready = 1'b1; out_bus.wready = 1'b1; out_bus.arready = 1'b1;
    out_bus.bid = '0; out_bus.bresp = '0; out_bus.buser = '0; out_bus.bvalid = 1'b0;
    out_bus.rid = '0; out_bus.rdata = '0; out_bus.rresp = '0; out_bus.rlast = 1'b0;
    out_bus.ruser = '0; out_bus.rvalid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [63:0] d, a;
    logic [15:0] id;
    logic [7:0]  len;
    logic [2:0]  size;
    bit          ok;

    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rvalid", in_bus.rvalid, 1'b0);
    check("rst_bvalid", in_bus.bvalid, 1'b0);
    check("rst_out_arvalid", out_bus.arvalid, 1'b0);
    check("rst_out_awvalid", out_bus.awvalid, 1'b0);
    rst_n = 1'b1;
    tick();

    // In-range read, four beats forwarded.
    id = 16'($urandom);
    in_bus.araddr = 64'h8_0000_0000; in_bus.arlen = 8'd3; in_bus.arsize = 3'd3;
    in_bus.arid = id; in_bus.arvalid = 1'b1;
    #1;
    check("ir_ar_valid", out_bus.arvalid, 1'b1);
    check("ir_ar_addr", out_bus.araddr, 64'h8_0000_0000);
    check("ir_ar_len", out_bus.arlen, 8'd3);
    check("ir_ar_ready", in_bus.arready, 1'b1);
    tick();
    in_bus.arvalid = 1'b0; in_bus.rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = {$urandom, $urandom};
      out_bus.rvalid = 1'b1; out_bus.rdata = d; out_bus.rid = id; out_bus.rlast = (i == 3);
      #1;
      check("ir_r_data", in_bus.rdata, d);
      check("ir_r_last", in_bus.rlast, (i == 3));
      tick();
    end
    out_bus.rvalid = 1'b0; out_bus.rlast = 1'b0;
    #1;
    check("ir_rd_cnt", dut.rd_cnt_q, 0);
    tick();

    // Out-of-range read: eight local DECERR beats.
    in_bus.araddr = Limit; in_bus.arid = 16'd5; in_bus.arlen = 8'd7; in_bus.arsize = 3'd0;
    in_bus.arvalid = 1'b1;
    #1;
    check("oor_ar_fwd", out_bus.arvalid, 1'b0);
    check("oor_ar_ready", in_bus.arready, 1'b1);
    tick();
    in_bus.arvalid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("oor_r_valid", in_bus.rvalid, 1'b1);
      check("oor_r_id", in_bus.rid, 16'd5);
      check("oor_r_resp", in_bus.rresp, 2'b11);
      check("oor_r_data", in_bus.rdata, 64'd0);
      check("oor_r_last", in_bus.rlast, (i == 7));
      check("oor_ar_quiet", out_bus.arvalid, 1'b0);
      tick();
    end
    #1;
    check("oor_r_done", in_bus.rvalid, 1'b0);
    tick();

    // Straddling write: sunk, then error B held under backpressure.
    in_bus.awaddr = 64'hF_FFFF_FFC0; in_bus.awsize = 3'd6; in_bus.awlen = 8'd1;
    in_bus.awid = 16'd2; in_bus.awvalid = 1'b1;
    #1;
    check("st_aw_fwd", out_bus.awvalid, 1'b0);
    check("st_aw_ready", in_bus.awready, 1'b1);
    tick();
    in_bus.awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_bus.wvalid = 1'b1; in_bus.wdata = {$urandom, $urandom}; in_bus.wlast = (i == 1);
      #1;
      check("st_w_ready", in_bus.wready, 1'b1);
      check("st_w_fwd", out_bus.wvalid, 1'b0);
      tick();
    end
    in_bus.wvalid = 1'b0; in_bus.wlast = 1'b0; in_bus.bready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("st_b_valid", in_bus.bvalid, 1'b1);
      check("st_b_id", in_bus.bid, 16'd2);
      check("st_b_resp", in_bus.bresp, 2'b11);
      tick();
    end
    in_bus.bready = 1'b1;
    tick();
    in_bus.bready = 1'b0;
    #1;
    check("st_b_done", in_bus.bvalid, 1'b0);
    tick();

    // Ordering: error beats wait for the earlier in-range read to finish.
    in_bus.araddr = 64'h100; in_bus.arid = 16'd1; in_bus.arlen = 8'd0; in_bus.arvalid = 1'b1;
    #1;
    check("ord_ar1_fwd", out_bus.arvalid, 1'b1);
    tick();
    in_bus.araddr = 64'hFFFF_FFFF_0000_0000; in_bus.arlen = 8'd1;
    #1;
    check("ord_ar2_fwd", out_bus.arvalid, 1'b0);
    check("ord_ar2_ready", in_bus.arready, 1'b1);
    tick();
    in_bus.arvalid = 1'b0; in_bus.rready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      check("ord_wait", in_bus.rvalid, 1'b0);
      tick();
    end
    d = {$urandom, $urandom};
    out_bus.rvalid = 1'b1; out_bus.rlast = 1'b1; out_bus.rid = 16'd1; out_bus.rdata = d;
    out_bus.rresp = 2'b00;
    #1;
    check("ord_ddr_data", in_bus.rdata, d);
    check("ord_ddr_resp", in_bus.rresp, 2'b00);
    tick();
    out_bus.rvalid = 1'b0; out_bus.rlast = 1'b0;
    #1;
    check("ord_err0_valid", in_bus.rvalid, 1'b1);
    check("ord_err0_resp", in_bus.rresp, 2'b11);
    check("ord_err0_last", in_bus.rlast, 1'b0);
    tick();
    #1;
    check("ord_err1_last", in_bus.rlast, 1'b1);
    tick();
    #1;
    check("ord_done", in_bus.rvalid, 1'b0);
    tick();

    // Outstanding limit on reads.
    in_bus.arlen = 8'd0; in_bus.arsize = 3'd0; in_bus.arvalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_bus.araddr = {32'd0, $urandom};
      #1;
      check("lim_accept", in_bus.arready, 1'b1);
      tick();
    end
    #1;
    check("lim_stall_rdy", in_bus.arready, 1'b0);
    check("lim_stall_fwd", out_bus.arvalid, 1'b0);
    tick();
    out_bus.rvalid = 1'b1; out_bus.rlast = 1'b1;
    #1;
    check("lim_still_stall", in_bus.arready, 1'b0);
    tick();
    out_bus.rvalid = 1'b0; out_bus.rlast = 1'b0;
    #1;
    check("lim_release", in_bus.arready, 1'b1);
    tick();
    in_bus.arvalid = 1'b0;
    out_bus.rvalid = 1'b1; out_bus.rlast = 1'b1;
    repeat (16) tick();
    out_bus.rvalid = 1'b0; out_bus.rlast = 1'b0;
    #1;
    check("lim_drained", dut.rd_cnt_q, 0);
    tick();

    // Reset in the middle of an error burst.
    in_bus.araddr = Limit + 64'h40; in_bus.arid = 16'd9; in_bus.arlen = 8'd7;
    in_bus.arvalid = 1'b1;
    tick();
    in_bus.arvalid = 1'b0;
    tick();
    tick();
    #1;
    check("rst_mid_valid", in_bus.rvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_drop", in_bus.rvalid, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    in_bus.araddr = 64'h40; in_bus.arlen = 8'd0; in_bus.arvalid = 1'b1;
    #1;
    check("rst_after_fwd", out_bus.arvalid, 1'b1);
    check("rst_after_rdy", in_bus.arready, 1'b1);
    tick();
    in_bus.arvalid = 1'b0;
    out_bus.rvalid = 1'b1; out_bus.rlast = 1'b1;
    tick();
    out_bus.rvalid = 1'b0; out_bus.rlast = 1'b0;
    in_bus.rready = 1'b0;
    tick();

    // Random single-burst traffic against the window rule.
    for (int n = 0; n < 60; n++) begin
      a = rand_addr();
      len = 8'($urandom_range(0, 3));
      size = 3'($urandom_range(0, 6));
      id = 16'($urandom);
      ok = model_ok(a, len, size);
      if ($urandom_range(0, 1) == 0) begin
        in_bus.awaddr = a; in_bus.awlen = len; in_bus.awsize = size; in_bus.awid = id;
        in_bus.awvalid = 1'b1;
        #1;
        check("rnd_aw_fwd", out_bus.awvalid, ok);
        check("rnd_aw_rdy", in_bus.awready, 1'b1);
        if (ok) check("rnd_aw_addr", out_bus.awaddr, a);
        tick();
        in_bus.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
          d = {$urandom, $urandom};
          in_bus.wvalid = 1'b1; in_bus.wdata = d; in_bus.wlast = (i == int'(len));
          #1;
          check("rnd_w_fwd", out_bus.wvalid, ok);
          if (ok) check("rnd_w_data", out_bus.wdata, d);
          tick();
        end
        in_bus.wvalid = 1'b0; in_bus.wlast = 1'b0; in_bus.bready = 1'b1;
        out_bus.bvalid = ok; out_bus.bid = id; out_bus.bresp = 2'b00;
        #1;
        check("rnd_b_valid", in_bus.bvalid, 1'b1);
        check("rnd_b_id", in_bus.bid, id);
        check("rnd_b_resp", in_bus.bresp, ok ? 2'b00 : 2'b11);
        tick();
        out_bus.bvalid = 1'b0; in_bus.bready = 1'b0;
      end else begin
        in_bus.araddr = a; in_bus.arlen = len; in_bus.arsize = size; in_bus.arid = id;
        in_bus.arvalid = 1'b1;
        #1;
        check("rnd_ar_fwd", out_bus.arvalid, ok);
        check("rnd_ar_rdy", in_bus.arready, 1'b1);
        tick();
        in_bus.arvalid = 1'b0; in_bus.rready = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
          d = {$urandom, $urandom};
          out_bus.rvalid = ok; out_bus.rdata = d; out_bus.rid = id; out_bus.rresp = 2'b00;
          out_bus.rlast = (i == int'(len));
          #1;
          check("rnd_r_valid", in_bus.rvalid, 1'b1);
          check("rnd_r_id", in_bus.rid, id);
          check("rnd_r_resp", in_bus.rresp, ok ? 2'b00 : 2'b11);
          check("rnd_r_data", in_bus.rdata, ok ? d : 64'd0);
          check("rnd_r_last", in_bus.rlast, (i == int'(len)));
          tick();
        end
        out_bus.rvalid = 1'b0; out_bus.rlast = 1'b0; in_bus.rready = 1'b0;
      end
      #1;
      check("rnd_idle_b", in_bus.bvalid, 1'b0);
      check("rnd_idle_r", in_bus.rvalid, 1'b0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
